// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, load encodings, bubble values.
package pipeline_pkg;

    localparam int PL_DATA_W     = 32;
    localparam int PL_REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        LD_WORD   = 3'b000,
        LD_BYTE_S = 3'b001,
        LD_BYTE_U = 3'b010,
        LD_HALF_S = 3'b011,
        LD_HALF_U = 3'b100
    } load_type_e;

    // Field values of an empty (reset or flushed) MEM/WB entry
    localparam logic       BUBBLE_VALID     = 1'b0;
    localparam logic       BUBBLE_REGWRITE  = 1'b0;
    localparam logic       BUBBLE_MEMTOREG  = 1'b0;
    localparam load_type_e BUBBLE_LOAD_TYPE = LD_WORD;

endpackage

// File: rtl/load_extract.sv
// Load lane selection, sign/zero extension and misalignment detection.
module load_extract
    import pipeline_pkg::*;
#(
    parameter int DATA_W = PL_DATA_W
) (
    input  logic              valid,
    input  logic              memtoreg,
    input  load_type_e        load_type,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] load_data,
    output logic              misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        is_byte;
    logic        is_half;
    logic        is_word;

    // Select the addressed lane and extend it to the datapath width
    always_comb begin
        byte_lane = read_data[7:0];
        case (addr_lo)
            2'd0: byte_lane = read_data[7:0];
            2'd1: byte_lane = read_data[15:8];
            2'd2: byte_lane = read_data[23:16];
            2'd3: byte_lane = read_data[31:24];
            default: byte_lane = read_data[7:0];
        endcase
        half_lane = addr_lo[1] ? read_data[31:16] : read_data[15:0];

        is_byte = (load_type == LD_BYTE_S) || (load_type == LD_BYTE_U);
        is_half = (load_type == LD_HALF_S) || (load_type == LD_HALF_U);
        is_word = !is_byte && !is_half;

        case (load_type)
            LD_BYTE_S: load_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
            LD_BYTE_U: load_data = {{(DATA_W-8){1'b0}}, byte_lane};
            LD_HALF_S: load_data = {{(DATA_W-16){half_lane[15]}}, half_lane};
            LD_HALF_U: load_data = {{(DATA_W-16){1'b0}}, half_lane};
            default:   load_data = read_data;
        endcase

        misaligned = valid && memtoreg &&
                     ((is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00)));
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, write-back select and retired-instruction counter.
module writeback_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W     = PL_DATA_W,
    parameter int REG_ADDR_W = PL_REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  Valid_In,
    input  logic                  RegWrite_In,
    input  logic                  MemtoReg_In,
    input  logic [2:0]            LoadType_In,
    input  logic [DATA_W-1:0]     ALUResult_In,
    input  logic [DATA_W-1:0]     ReadData_In,
    input  logic [REG_ADDR_W-1:0] RegDestAddress_In,
    output logic                  Valid_Out,
    output logic                  RegWrite_Out,
    output logic [REG_ADDR_W-1:0] RegDestAddress_Out,
    output logic [DATA_W-1:0]     WriteBackData_Out,
    output logic                  Misaligned_Out,
    output logic [CNT_W-1:0]      Retired_Count
);

    logic                  valid_q,    valid_d;
    logic                  regwrite_q, regwrite_d;
    logic                  memtoreg_q, memtoreg_d;
    load_type_e            loadtype_q, loadtype_d;
    logic [DATA_W-1:0]     aluresult_q, aluresult_d;
    logic [DATA_W-1:0]     readdata_q, readdata_d;
    logic [REG_ADDR_W-1:0] dest_q,     dest_d;
    logic [CNT_W-1:0]      count_q,    count_d;

    logic [DATA_W-1:0]     load_data;
    logic                  misaligned;

    load_extract #(.DATA_W(DATA_W)) u_load_extract (
        .valid      (valid_q),
        .memtoreg   (memtoreg_q),
        .load_type  (loadtype_q),
        .addr_lo    (aluresult_q[1:0]),
        .read_data  (readdata_q),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // Next entry by priority Flush > Stall > capture; count the entry leaving the register
    always_comb begin
        valid_d     = Valid_In;
        regwrite_d  = RegWrite_In;
        memtoreg_d  = MemtoReg_In;
        loadtype_d  = load_type_e'(LoadType_In);
        aluresult_d = ALUResult_In;
        readdata_d  = ReadData_In;
        dest_d      = RegDestAddress_In;
        if (Flush) begin
            valid_d     = BUBBLE_VALID;
            regwrite_d  = BUBBLE_REGWRITE;
            memtoreg_d  = BUBBLE_MEMTOREG;
            loadtype_d  = BUBBLE_LOAD_TYPE;
            aluresult_d = '0;
            readdata_d  = '0;
            dest_d      = '0;
        end else if (Stall) begin
            valid_d     = valid_q;
            regwrite_d  = regwrite_q;
            memtoreg_d  = memtoreg_q;
            loadtype_d  = loadtype_q;
            aluresult_d = aluresult_q;
            readdata_d  = readdata_q;
            dest_d      = dest_q;
        end

        // A stalled entry is still in place, so it is only counted once, when it leaves
        count_d = count_q;
        if (valid_q && (!Stall || Flush) && !misaligned)
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Register update; reset dominates flush, stall and counting
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q     <= BUBBLE_VALID;
            regwrite_q  <= BUBBLE_REGWRITE;
            memtoreg_q  <= BUBBLE_MEMTOREG;
            loadtype_q  <= BUBBLE_LOAD_TYPE;
            aluresult_q <= '0;
            readdata_q  <= '0;
            dest_q      <= '0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            loadtype_q  <= loadtype_d;
            aluresult_q <= aluresult_d;
            readdata_q  <= readdata_d;
            dest_q      <= dest_d;
            count_q     <= count_d;
        end
    end

    // Outputs depend only on registered fields; $zero and misaligned loads never write
    always_comb begin
        Valid_Out          = valid_q;
        RegDestAddress_Out = dest_q;
        Misaligned_Out     = misaligned;
        WriteBackData_Out  = memtoreg_q ? load_data : aluresult_q;
        RegWrite_Out       = valid_q && regwrite_q && (dest_q != '0) && !misaligned;
        Retired_Count      = count_q;
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage with a small counter to exercise wrap.
module tb_writeback_stage;

    localparam int CNT_W = 4;

    logic        Clk = 1'b0;
    logic        Rst, Stall, Flush, Valid_In, RegWrite_In, MemtoReg_In;
    logic [2:0]  LoadType_In;
    logic [31:0] ALUResult_In, ReadData_In;
    logic [4:0]  RegDestAddress_In;
    logic        Valid_Out, RegWrite_Out, Misaligned_Out;
    logic [4:0]  RegDestAddress_Out;
    logic [31:0] WriteBackData_Out;
    logic [CNT_W-1:0] Retired_Count;

    int checks = 0;
    int failures = 0;

    // Reference model: the entry currently held plus the retire count
    logic        m_valid, m_rw, m_m2r;
    int unsigned m_lt, m_alu, m_rd, m_dest, m_cnt;

    writeback_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .Valid_In(Valid_In),
        .RegWrite_In(RegWrite_In), .MemtoReg_In(MemtoReg_In), .LoadType_In(LoadType_In),
        .ALUResult_In(ALUResult_In), .ReadData_In(ReadData_In),
        .RegDestAddress_In(RegDestAddress_In), .Valid_Out(Valid_Out),
        .RegWrite_Out(RegWrite_Out), .RegDestAddress_Out(RegDestAddress_Out),
        .WriteBackData_Out(WriteBackData_Out), .Misaligned_Out(Misaligned_Out),
        .Retired_Count(Retired_Count)
    );

    always #5 Clk = ~Clk;

    function automatic int unsigned exp_data();
        int unsigned b, h;
        if (!m_m2r) return m_alu;
        b = (m_rd / (2 ** (8 * (m_alu % 4)))) % 256;
        h = (m_rd / (2 ** (16 * ((m_alu / 2) % 2)))) % 65536;
        case (m_lt)
            1: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            2: return b;
            3: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            4: return h;
            default: return m_rd;
        endcase
    endfunction

    function automatic logic exp_mis();
        if (!m_valid || !m_m2r) return 1'b0;
        if (m_lt == 3 || m_lt == 4) return (m_alu % 2) != 0;
        if (m_lt == 1 || m_lt == 2) return 1'b0;
        return (m_alu % 4) != 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic mis;
        mis = exp_mis();
        chk("valid", {31'd0, Valid_Out}, {31'd0, m_valid});
        chk("dest", {27'd0, RegDestAddress_Out}, m_dest);
        chk("wbdata", WriteBackData_Out, exp_data());
        chk("misaligned", {31'd0, Misaligned_Out}, {31'd0, mis});
        chk("regwrite", {31'd0, RegWrite_Out},
            {31'd0, m_valid && m_rw && (m_dest != 0) && !mis});
        chk("count", {28'd0, Retired_Count}, m_cnt % (2 ** CNT_W));
    endtask

    // One rising edge: update the model from the applied inputs, then compare
    task automatic cycle();
        @(posedge Clk);
        if (Rst) begin
            m_valid = 0; m_rw = 0; m_m2r = 0; m_lt = 0; m_alu = 0; m_rd = 0; m_dest = 0;
            m_cnt = 0;
        end else begin
            if (m_valid && (!Stall || Flush) && !exp_mis()) m_cnt = m_cnt + 1;
            if (Flush) begin
                m_valid = 0; m_rw = 0; m_m2r = 0; m_lt = 0; m_alu = 0; m_rd = 0; m_dest = 0;
            end else if (!Stall) begin
                m_valid = Valid_In; m_rw = RegWrite_In; m_m2r = MemtoReg_In;
                m_lt = LoadType_In; m_alu = ALUResult_In; m_rd = ReadData_In;
                m_dest = RegDestAddress_In;
            end
        end
        #1;
        check_all();
    endtask

    task automatic drive(input logic rst, input logic stl, input logic fl, input logic v,
                         input logic rw, input logic m2r, input logic [2:0] lt,
                         input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] dst);
        Rst = rst; Stall = stl; Flush = fl; Valid_In = v; RegWrite_In = rw;
        MemtoReg_In = m2r; LoadType_In = lt; ALUResult_In = alu; ReadData_In = rd;
        RegDestAddress_In = dst;
        cycle();
    endtask

    initial begin
        m_valid = 0; m_rw = 0; m_m2r = 0; m_lt = 0; m_alu = 0; m_rd = 0; m_dest = 0; m_cnt = 0;

        // Reset with arbitrary inputs
        drive(1, 1, 0, 1, 1, 1, 3'd3, 32'h1234_5677, 32'hDEAD_BEEF, 5'd7);
        drive(1, 0, 0, 1, 1, 0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        chk("reset_count", {28'd0, Retired_Count}, 32'd0);
        chk("reset_wb", WriteBackData_Out, 32'd0);

        // ALU write-back
        drive(0, 0, 0, 1, 1, 0, 3'd0, 32'h0000_0001, 32'h0, 5'b10000);
        chk("alu_wb", WriteBackData_Out, 32'h0000_0001);
        chk("alu_rw", {31'd0, RegWrite_Out}, 32'd1);

        // Loads from 0x80FF7F01 (each also retires the previous entry)
        drive(0, 0, 0, 1, 1, 1, 3'd1, 32'h0000_1002, 32'h80FF_7F01, 5'd3);
        chk("alu_count", {28'd0, Retired_Count}, 32'd1);
        chk("lb", WriteBackData_Out, 32'hFFFF_FFFF);
        drive(0, 0, 0, 1, 1, 1, 3'd2, 32'h0000_1003, 32'h80FF_7F01, 5'd3);
        chk("lbu", WriteBackData_Out, 32'h0000_0080);
        drive(0, 0, 0, 1, 1, 1, 3'd3, 32'h0000_1000, 32'h80FF_7F01, 5'd3);
        chk("lh", WriteBackData_Out, 32'h0000_7F01);
        drive(0, 0, 0, 1, 1, 1, 3'd4, 32'h0000_1002, 32'h80FF_7F01, 5'd3);
        chk("lhu", WriteBackData_Out, 32'h0000_80FF);

        // Misaligned half and word loads
        drive(0, 0, 0, 1, 1, 1, 3'd3, 32'h0000_1001, 32'h80FF_7F01, 5'd4);
        chk("mis_half", {31'd0, Misaligned_Out}, 32'd1);
        drive(0, 0, 0, 1, 1, 1, 3'd0, 32'h0000_1002, 32'h80FF_7F01, 5'd4);
        chk("mis_word_rw", {31'd0, RegWrite_Out}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0);

        // Stall holds entry A, then Stall+Flush bubbles and retires it
        drive(0, 0, 0, 1, 1, 0, 3'd0, 32'hAAAA_0000, 32'h0, 5'd9);
        for (int i = 0; i < 3; i++)
            drive(0, 1, 0, 1, 1, 0, 3'd0, $urandom, $urandom, 5'($urandom));
        chk("stall_hold", WriteBackData_Out, 32'hAAAA_0000);
        drive(0, 1, 1, 1, 1, 0, 3'd0, $urandom, $urandom, 5'd1);
        chk("flush_bubble", {31'd0, Valid_Out}, 32'd0);

        // Write to $zero is suppressed
        drive(0, 0, 0, 1, 1, 0, 3'd0, 32'h55, 32'h0, 5'd0);
        chk("zero_rw", {31'd0, RegWrite_Out}, 32'd0);

        // Wrap: 17 retirements into a 4-bit counter
        drive(1, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 17; i++)
            drive(0, 0, 0, 1, 1, 0, 3'd0, i, 32'h0, 5'd2);
        drive(0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0);
        chk("wrap", {28'd0, Retired_Count}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25),
                  ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 80),
                  1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                  $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Downstream neighbour of the Memory stage: MEM/WB pipeline register plus the write-back path of the pipelined MIPS datapath.
- Captures Memory-stage outputs (RegWrite, MemtoReg, ALUResult, ReadData, RegDestAddress) each cycle.
- Performs load-size extraction and sign/zero extension, then selects the write-back value.
- Drives the register-file write port and the WB forwarding source. Adds stall/flush control, alignment checking and a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width.
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst  in  1  synchronous reset, active-high.
- Stall  in  1  hold the MEM/WB register contents.
- Flush  in  1  load a bubble instead of the incoming entry.
- Valid_In  in  1  incoming entry is a real instruction.
- RegWrite_In  in  1  incoming entry writes the register file.
- MemtoReg_In  in  1  1 = write back load data, 0 = ALUResult.
- LoadType_In  in  3  load size/sign encoding (see Behaviour).
- ALUResult_In  in  DATA_W  ALU result / load address.
- ReadData_In  in  DATA_W  raw word from data memory.
- RegDestAddress_In  in  REG_ADDR_W  destination register.
- Valid_Out  out  1  registered entry is valid.
- RegWrite_Out  out  1  register-file write enable.
- RegDestAddress_Out  out  REG_ADDR_W  register-file write address.
- WriteBackData_Out  out  DATA_W  register-file write data / forwarding value.
- Misaligned_Out  out  1  registered load is misaligned; its write is suppressed.
- Retired_Count  out  CNT_W  count of retired valid instructions.

Behaviour:
- Clock and reset: one clock (Clk); reset Rst is synchronous, active-high.
- Update priority per rising edge: Rst > Flush > Stall > capture.
- Rst: all register fields = 0, Retired_Count = 0.
  - Outputs after reset: Valid_Out = 0, RegWrite_Out = 0, RegDestAddress_Out = 0, WriteBackData_Out = 0, Misaligned_Out = 0.
- Flush: register fields = 0 (bubble). Flush overrides a simultaneous Stall.
- Stall (no Flush): all register fields hold their values.
- Capture: all *_In values are registered. Latency is one cycle from input to outputs.
- Outputs are combinational from registered fields only; there is no input-to-output combinational path.
- LoadType (used only when MemtoReg = 1); byte lanes are little-endian, lane k = bits 8k+7:8k:
  - 000: word.
  - 001: byte, sign-extended (LB).
  - 010: byte, zero-extended (LBU).
  - 011: half, sign-extended (LH).
  - 100: half, zero-extended (LHU).
  - 101–111: treated as word.
- Lane selection: byte lane = ALUResult[1:0]; half = ALUResult[1] ? bits 31:16 : bits 15:0.
- Misaligned_Out = valid & MemtoReg & ((half & ALUResult[0]) | (word & ALUResult[1:0] != 0)).
- WriteBackData_Out = MemtoReg ? extracted load value : ALUResult. It is always driven, even when RegWrite_Out = 0.
- RegWrite_Out = valid & RegWrite & (RegDestAddress != 0) & !Misaligned_Out. Writes to $zero are never issued.
- Retire: an entry retires on the edge where it leaves the register, i.e. current entry valid and (!Stall | Flush), and Rst = 0.
  - Retired_Count increments by 1 only if that entry is not misaligned.
  - The counter wraps modulo 2^CNT_W.
- During a stall the same write is presented for several cycles. This is idempotent and counts once.
- Reset mid-stall or mid-flush: Rst wins; the counter does not increment on that edge.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - LoadType encodings: LD_WORD, LD_BYTE_S, LD_BYTE_U, LD_HALF_S, LD_HALF_U.
  - DATA_W / REG_ADDR_W defaults.
  - Reset/bubble constants.
- One natural sub-module, load_extract: combinational lane select plus sign/zero extension plus the misalignment flag. The top level keeps the register, control priority and counter.

Test Plan:
- Reset: assert Rst 2 cycles with arbitrary inputs -> all outputs 0 and Retired_Count = 0 on the cycle after Rst deasserts.
- ALU write-back: Valid=1, RegWrite=1, MemtoReg=0, ALUResult=0x00000001, Dest=5'b10000 -> next cycle RegWrite_Out=1, Dest_Out=16, WriteBackData_Out=0x00000001; count becomes 1 one edge later.
- Load extraction: ReadData=0x80FF7F01, MemtoReg=1:
  - LB at addr[1:0]=2 -> 0xFFFFFFFF.
  - LBU at addr 3 -> 0x00000080.
  - LH at addr 0 -> 0x00007F01.
  - LHU at addr 2 -> 0x000080FF.
- Misalignment: LH at addr 0x1001, or word at addr 0x1002, RegWrite=1 -> Misaligned_Out=1, RegWrite_Out=0; counter does not increment when the entry leaves.
- Stall/flush: capture entry A, Stall 3 cycles while inputs change -> outputs hold A, count unchanged. Then Stall+Flush together -> bubble (Valid_Out=0), count +1 for A.
- $zero and wrap: Dest=0, RegWrite=1 -> RegWrite_Out=0. With CNT_W=4, retire 17 valid entries -> Retired_Count=1.
